// File: rtl/xenke_pkg.sv
// Shared definitions for the alternating-pattern generator/checker pair:
// state encoding, the PA pattern, and the width rule for saturating counters.
package xenke_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Alternating pattern with MSB=1 (8'hAA at w=8); callers keep the low w bits.
  function automatic logic [63:0] pa_pattern(input int w);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < w && i < 64; i++) begin
      p[i] = ((w - 1 - i) % 2) == 0;
    end
    return p;
  endfunction

  // A saturating add keeps one carry bit above the counter width.
  function automatic int sat_sum_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  // Width needed to hold a popcount of a w-bit word.
  function automatic int popcnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xenke_popcnt.sv
// Combinational population count of a W-bit word.
// Zero latency, no flow control.
module xenke_popcnt
  import xenke_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]             d,
  output logic [popcnt_w(W)-1:0]   cnt
);

  localparam int PW = popcnt_w(W);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(d[i]);
    end
  end

endmodule

// File: rtl/xenke_chk.sv
// Receive checker for the alternating PA/PB stream: hunts, locks, counts errors; all outputs registered (1 cycle), samples only on dv, no backpressure.
// XENKE_CHK_BITERR_EN switches err_cnt from word errors to mismatching-bit counts.
module xenke_chk
  import xenke_pkg::*;
#(
  parameter int W        = 8,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [W-1:0]     d,
  input  logic             dv,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     exp_o
);

  localparam logic [63:0]  PA64 = pa_pattern(W);
  localparam logic [W-1:0] PA   = PA64[W-1:0];
  localparam logic [W-1:0] PB   = ~PA;
  localparam int           SW   = sat_sum_w(CNT_W);

  state_t         state_q, state_nxt;
  logic [W-1:0]   exp_q, exp_nxt;
  logic [3:0]     good_q, good_nxt;
  logic [3:0]     bad_q, bad_nxt;
  logic           err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SW-1:0]  inc_amt;
  logic [SW-1:0]  base;
  logic [SW-1:0]  sum;

  wire is_pat = (d == PA) || (d == PB);

`ifdef XENKE_CHK_BITERR_EN
  localparam int PW = popcnt_w(W);
  logic [PW-1:0] pc;

  xenke_popcnt #(.W(W)) u_popcnt (
    .d   (d ^ exp_q),
    .cnt (pc)
  );

  assign inc_amt = SW'(pc);
`else
  assign inc_amt = SW'(1);
`endif

  always_comb begin
    state_nxt = state_q;
    exp_nxt   = exp_q;
    good_nxt  = good_q;
    bad_nxt   = bad_q;
    err_nxt   = 1'b0;
    case (state_q)
      HUNT: begin
        if (dv && is_pat) begin
          exp_nxt   = ~d;
          good_nxt  = 4'd1;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (dv) begin
          if (d == exp_q) begin
            exp_nxt  = ~d;
            good_nxt = good_q + 4'd1;
            if (({1'b0, good_q} + 5'd1) == 5'(LOCK_N)) begin
              state_nxt = LOCK;
              bad_nxt   = 4'd0;
            end
          end else if (is_pat) begin
            exp_nxt  = ~d;
            good_nxt = 4'd1;
          end else begin
            good_nxt  = 4'd0;
            state_nxt = HUNT;
          end
        end
      end
      LOCK: begin
        if (dv) begin
          // Phase free-runs once locked; bad data never re-aligns it.
          exp_nxt = ~exp_q;
          if (d == exp_q) begin
            bad_nxt = 4'd0;
          end else begin
            err_nxt = 1'b1;
            bad_nxt = bad_q + 4'd1;
            if (({1'b0, bad_q} + 5'd1) == 5'(UNLOCK_N)) begin
              state_nxt = HUNT;
            end
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Clear takes effect before the new error is added.
  always_comb begin
    base    = clr ? '0 : {1'b0, err_cnt};
    sum     = base + inc_amt;
    cnt_nxt = base[CNT_W-1:0];
    if (err_nxt) begin
      cnt_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q <= HUNT;
      exp_q   <= PA;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      exp_q   <= exp_nxt;
      good_q  <= good_nxt;
      bad_q   <= bad_nxt;
      locked  <= (state_nxt == LOCK);
      err     <= err_nxt;
      err_cnt <= cnt_nxt;
    end
  end

  assign exp_o = exp_q;

endmodule

// File: tb/tb_xenke_chk.sv
// Directed, table-driven bench for xenke_chk: default instance for lock/error flow,
// a CNT_W=4 / UNLOCK_N=15 instance for saturation and clear.
module tb_xenke_chk;

`ifdef XENKE_CHK_BITERR_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rs;
  logic [7:0]  d0, d1;
  logic        dv0, dv1, clr0, clr1;
  logic        locked0, err0, locked1, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [7:0]  expo0, expo1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xenke_chk #(.W(8), .LOCK_N(4), .UNLOCK_N(3), .CNT_W(16)) u0 (
    .clk(clk), .rs(rs), .d(d0), .dv(dv0), .clr(clr0),
    .locked(locked0), .err(err0), .err_cnt(cnt0), .exp_o(expo0)
  );

  xenke_chk #(.W(8), .LOCK_N(4), .UNLOCK_N(15), .CNT_W(4)) u1 (
    .clk(clk), .rs(rs), .d(d1), .dv(dv1), .clr(clr1),
    .locked(locked1), .err(err1), .err_cnt(cnt1), .exp_o(expo1)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  d;
    logic        dv;
    logic        clr;
    logic        el;
    logic        ee;
    logic [15:0] ec;
    logic [7:0]  ex;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [7:0] dd, input logic v, input logic c,
                     input logic el, input logic ee, input logic [15:0] ec, input logic [7:0] ex);
    vec_t t;
    t.rst = r; t.d = dd; t.dv = v; t.clr = c;
    t.el = el; t.ee = ee; t.ec = ec; t.ex = ex;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input int u, input logic el, input logic ee,
                     input logic [15:0] ec, input logic [7:0] ex);
    logic al, ae;
    logic [15:0] ac;
    logic [7:0] ax;
    if (u == 0) begin al = locked0; ae = err0; ac = cnt0; ax = expo0; end
    else begin al = locked1; ae = err1; ac = {12'd0, cnt1}; ax = expo1; end
    checks++;
    if (al !== el || ae !== ee || ac !== ec || ax !== ex) begin
      errors++;
      $display("FAIL %s: got locked=%0b err=%0b cnt=%0d exp_o=%h, want locked=%0b err=%0b cnt=%0d exp_o=%h",
               name, al, ae, ac, ax, el, ee, ec, ex);
    end
  endtask

  task automatic drive(input int u, input logic [7:0] dd, input logic v, input logic c);
    @(negedge clk);
    dv0 = 1'b0; clr0 = 1'b0; dv1 = 1'b0; clr1 = 1'b0;
    if (u == 0) begin d0 = dd; dv0 = v; clr0 = c; end
    else begin d1 = dd; dv1 = v; clr1 = c; end
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted between edges and checked before any clock arrives.
  task automatic async_rst(input string name, input int u);
    @(negedge clk);
    dv0 = 1'b0; clr0 = 1'b0; dv1 = 1'b0; clr1 = 1'b0;
    rs = 1'b0;
    #1;
    chk(name, u, 1'b0, 1'b0, 16'd0, 8'hAA);
    #1;
    rs = 1'b1;
  endtask

  initial begin
    rs = 1'b0;
    d0 = 8'h00; d1 = 8'h00;
    dv0 = 1'b0; dv1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_u0", 0, 1'b0, 1'b0, 16'd0, 8'hAA);
    chk("reset_u1", 1, 1'b0, 1'b0, 16'd0, 8'hAA);
    rs = 1'b1;

    // Acquire lock, idle cycle, single error, burst-to-unlock, relock.
    add(0, 8'hAA, 1, 0, 0, 0, 16'd0, 8'h55);
    add(0, 8'h55, 1, 0, 0, 0, 16'd0, 8'hAA);
    add(0, 8'hAA, 1, 0, 0, 0, 16'd0, 8'h55);
    add(0, 8'h55, 1, 0, 1, 0, 16'd0, 8'hAA);
    add(0, 8'h33, 0, 0, 1, 0, 16'd0, 8'hAA);
    add(0, 8'hAA, 1, 0, 1, 0, 16'd0, 8'h55);
    add(0, 8'h00, 1, 0, 1, 1, BE ? 16'd4 : 16'd1, 8'hAA);
    add(0, 8'hAA, 1, 0, 1, 0, BE ? 16'd4 : 16'd1, 8'h55);
    add(0, 8'h55, 1, 0, 1, 0, BE ? 16'd4 : 16'd1, 8'hAA);
    add(0, 8'h00, 1, 0, 1, 1, BE ? 16'd8 : 16'd2, 8'h55);
    add(0, 8'hFF, 1, 0, 1, 1, BE ? 16'd12 : 16'd3, 8'hAA);
    add(0, 8'h12, 1, 0, 0, 1, BE ? 16'd16 : 16'd4, 8'h55);
    add(0, 8'hAA, 1, 0, 0, 0, BE ? 16'd16 : 16'd4, 8'h55);
    add(0, 8'h55, 1, 0, 0, 0, BE ? 16'd16 : 16'd4, 8'hAA);
    add(0, 8'hAA, 1, 0, 0, 0, BE ? 16'd16 : 16'd4, 8'h55);
    add(0, 8'h55, 1, 0, 1, 0, BE ? 16'd16 : 16'd4, 8'hAA);
    // Hunt rejects garbage, sync drops on garbage, sync restarts on phase slip.
    add(1, 8'h00, 0, 0, 0, 0, 16'd0, 8'hAA);
    add(0, 8'h12, 1, 0, 0, 0, 16'd0, 8'hAA);
    add(0, 8'hAA, 1, 0, 0, 0, 16'd0, 8'h55);
    add(0, 8'h00, 1, 0, 0, 0, 16'd0, 8'h55);
    add(0, 8'hAA, 1, 0, 0, 0, 16'd0, 8'h55);
    add(0, 8'h55, 1, 0, 0, 0, 16'd0, 8'hAA);
    add(0, 8'h55, 1, 0, 0, 0, 16'd0, 8'hAA);
    add(0, 8'hAA, 1, 0, 0, 0, 16'd0, 8'h55);
    add(0, 8'h55, 1, 0, 0, 0, 16'd0, 8'hAA);
    add(0, 8'hAA, 1, 0, 1, 0, 16'd0, 8'h55);
    // 0x5A against expected 0x55 differs in four bits.
    add(0, 8'h5A, 1, 0, 1, 1, BE ? 16'd4 : 16'd1, 8'hAA);
    add(0, 8'hAA, 1, 1, 1, 0, 16'd0, 8'h55);
    add(0, 8'h5A, 1, 0, 1, 1, BE ? 16'd4 : 16'd1, 8'hAA);
    add(1, 8'h00, 0, 0, 0, 0, 16'd0, 8'hAA);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) begin
        async_rst($sformatf("u0_rst_v%0d", i), 0);
      end else begin
        drive(0, tv[i].d, tv[i].dv, tv[i].clr);
        chk($sformatf("u0_v%0d", i), 0, tv[i].el, tv[i].ee, tv[i].ec, tv[i].ex);
      end
    end

    // Saturation at CNT_W=4 across an unlock/relock, then clear colliding with an error.
    async_rst("u1_rst", 1);
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'h55, 1, 0);
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'h55, 1, 0);
    chk("u1_lock", 1, 1'b1, 1'b0, 16'd0, 8'hAA);
    for (int i = 0; i < 15; i++) begin
      drive(1, 8'h00, 1, 0);
      if (i == 13) chk("u1_bad14", 1, 1'b1, 1'b1, BE ? 16'd15 : 16'd14, 8'hAA);
      if (i == 14) chk("u1_unlock", 1, 1'b0, 1'b1, 16'd15, 8'h55);
    end
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'h55, 1, 0);
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'h55, 1, 0);
    chk("u1_relock", 1, 1'b1, 1'b0, 16'd15, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h00, 1, 0);
      chk($sformatf("u1_sat%0d", i), 1, 1'b1, 1'b1, 16'd15, (i % 2 == 0) ? 8'h55 : 8'hAA);
    end
    drive(1, 8'h00, 1, 1);
    chk("u1_clr_err", 1, 1'b1, 1'b1, BE ? 16'd4 : 16'd1, 8'hAA);
    drive(1, 8'hAA, 1, 1);
    chk("u1_clr_only", 1, 1'b1, 1'b0, 16'd0, 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xenke_chk.md
Name: xenke_chk

Overview:
- Receive-side checker for the alternating-pattern generator (0xAA/0x55 toggling every clock).
- Samples a W-bit bus under a valid strobe and acquires lock on the alternating sequence.
- Once locked, flags and counts errors, then drops lock after repeated misses.
- Sits at the far end of the link or loopback path and gives pass/fail status to the test harness.

Parameters:
- W, 8, data width; PA = alternating pattern with MSB=1 (8'hAA at W=8), PB = ~PA
- LOCK_N, 4, consecutive correct samples required to lock; legal 2..15
- UNLOCK_N, 3, consecutive bad samples while locked that force loss of lock; legal 1..15
- CNT_W, 16, error counter width

Ports:
- clk  in  1  system clock, rising edge
- rs  in  1  reset, asynchronous, active-low (rs=0 resets)
- d  in  W  received data
- dv  in  1  d valid; the block samples only when dv=1
- clr  in  1  synchronous clear of err_cnt
- locked  out  1  high while in LOCK
- err  out  1  one-cycle pulse per erroneous sample while locked
- err_cnt  out  CNT_W  saturating error count
- exp_o  out  W  expected next pattern (debug)

Behaviour:
- Reset (rs=0, asynchronous): state=HUNT, locked=0, err=0, err_cnt=0, exp=PA, good_cnt=0, bad_cnt=0.
- All outputs are registered. Each response appears on the cycle after the sampling edge; there is no combinational path from inputs to outputs.
- While dv=0, nothing changes and err=0.
- HUNT:
  - On dv with d==PA or d==PB: exp<=~d, good_cnt<=1, go to SYNC.
  - Otherwise stay in HUNT.
- SYNC:
  - On dv with d==exp: exp<=~d and good_cnt++. If good_cnt+1==LOCK_N, go to LOCK with bad_cnt<=0.
  - On dv with d!=exp but d equal to PA or PB: restart, with exp<=~d, good_cnt<=1, stay in SYNC.
  - On dv with any other value: go to HUNT, good_cnt<=0.
  - No errors are counted in HUNT or SYNC.
- LOCK:
  - On every dv, exp<=~exp. The phase free-runs and never resyncs to bad data.
  - Match: bad_cnt<=0.
  - Mismatch: err=1 on the next cycle, err_cnt increments (saturating at all-ones), bad_cnt++. If bad_cnt+1==UNLOCK_N, go to HUNT with locked=0 on the next cycle.
- locked = (state==LOCK), registered.
- When clr and an error occur in the same cycle, err_cnt=1. The clear applies first, then the new error is counted.
- err_cnt holds at 2^CNT_W-1 and does not wrap. The err pulse still fires at saturation.
- Asserting reset mid-stream returns every register to its reset value immediately. There is no recovery of partial state.
- State encoding: 2-bit HUNT=0, SYNC=1, LOCK=2. The unused code 3 goes to HUNT.

Optional Feature:
- Macro: XENKE_CHK_BITERR_EN.
- When defined:
  - err_cnt accumulates the number of mismatching bits, popcount(d ^ exp), instead of 1 per bad word.
  - The increment saturates and is added in a single cycle.
  - The clr+error case gives err_cnt = popcount.
- When undefined: word-error counting as specified above, and no popcount logic is built.
- Port list is identical in both builds.

Decomposition:
- Shared package xenke_pkg holds:
  - the state enum (HUNT/SYNC/LOCK);
  - the pattern function/constant PA(W);
  - the saturating-add width rule.
- The generator and the checker both use PA from this package.
- One natural sub-module: xenke_popcnt (W-bit popcount). It is instantiated only under XENKE_CHK_BITERR_EN.

Test Plan:
1. Reset then stream AA,55,AA,55 with dv=1 every cycle → locked=1 the cycle after the 4th sample, err_cnt=0, exp_o=AA.
2. Locked, inject 0x00 once in place of 55 then resume correct phase → one err pulse, err_cnt=1, locked stays 1, next AA accepted with no error.
3. Locked, inject three consecutive bad words (0x00,0xFF,0x12) → err_cnt=3, locked falls after the third; a new AA,55,AA,55 relocks.
4. In SYNC after AA,55, send 55 (phase slip) → good_cnt restarts at 1; three further correct samples are needed before lock, and no error is counted.
5. CNT_W=4, locked, drive 20 bad words with UNLOCK_N=15 and a relock between → err_cnt holds at 15. Pulse clr while an error arrives → err_cnt=1.
6. With XENKE_CHK_BITERR_EN, locked, send 0x5A when expecting 0x55 → err_cnt increases by 4. Assert rs mid-stream → every output is 0 immediately and exp_o=AA.
